lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 57 +++++
 rtl/lsu_align.sv | 89 ++++++++
 rtl/lsu.sv | 216 +++++++++++++++++++++
 tb/tb_lsu.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Optional feature: LSU_MISALIGN_EN enables split (misaligned) accesses
// and the ACC1 state; without it a split access completes with an error.
package lsu_pkg;

  // Access size/extension encoding carried on req_ctrl.
  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } ls_ctrl_e;

`ifdef LSU_MISALIGN_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } lsu_state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    RESP = 2'd3
  } lsu_state_e;
`endif

  // Number of bytes touched by an access of the given encoding.
  function automatic logic [2:0] ls_size(input logic [2:0] ctrl);
    logic [2:0] sz;
    case (ctrl[1:0])
      2'b00:   sz = 3'd1;
      2'b01:   sz = 3'd2;
      default: sz = 3'd4;
    endcase
    return sz;
  endfunction

  // Encodings that exist, and unsigned variants only make sense for loads.
  function automatic logic ls_legal(input logic we, input logic [2:0] ctrl);
    logic ok;
    case (ctrl)
      LS_B, LS_H, LS_W: ok = 1'b1;
      LS_BU, LS_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // An access is split when it runs past the end of its 32-bit word.
  function automatic logic ls_split(input logic [1:0] addr_lo, input logic [2:0] ctrl);
    return (({1'b0, addr_lo} + ls_size(ctrl)) > 3'd4);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the LSU: store byte enables and data shifting, and
// load word assembly plus sign/zero extension. Purely combinational.
// With LSU_MISALIGN_EN the upper halves (spill into the next word) are
// produced as well; otherwise only the single-word view exists.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  ctrl_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_lo_i,
`ifdef LSU_MISALIGN_EN
  input  logic [31:0] rdata_hi_i,
  output logic [3:0]  be1_o,
  output logic [31:0] wdata1_o,
`endif
  output logic [3:0]  be0_o,
  output logic [31:0] wdata0_o,
  output logic [31:0] ldata_o
);

  logic [4:0]  sh;
  logic [31:0] wmask;
  logic [31:0] word;
`ifdef LSU_MISALIGN_EN
  logic [7:0]  be_base;
  logic [7:0]  be_wide;
  logic [63:0] w_wide;
`else
  logic [3:0]  be_base;
`endif

  // Shift store lanes and enables by the byte offset; gather load bytes.
  always_comb begin
    sh = {off_i, 3'b000};
    case (ls_size(ctrl_i))
      3'd1: begin
`ifdef LSU_MISALIGN_EN
        be_base = 8'h01;
`else
        be_base = 4'h1;
`endif
        wmask = 32'h0000_00FF;
      end
      3'd2: begin
`ifdef LSU_MISALIGN_EN
        be_base = 8'h03;
`else
        be_base = 4'h3;
`endif
        wmask = 32'h0000_FFFF;
      end
      default: begin
`ifdef LSU_MISALIGN_EN
        be_base = 8'h0F;
`else
        be_base = 4'hF;
`endif
        wmask = 32'hFFFF_FFFF;
      end
    endcase
`ifdef LSU_MISALIGN_EN
    be_wide  = be_base << off_i;
    w_wide   = {32'd0, wdata_i & wmask} << sh;
    be0_o    = be_wide[3:0];
    be1_o    = be_wide[7:4];
    wdata0_o = w_wide[31:0];
    wdata1_o = w_wide[63:32];
    // A zero offset shifts the high word out entirely (shift by 32).
    word     = (rdata_lo_i >> sh) | (rdata_hi_i << (6'd32 - {1'b0, sh}));
`else
    be0_o    = be_base << off_i;
    wdata0_o = (wdata_i & wmask) << sh;
    word     = rdata_lo_i >> sh;
`endif
  end

  // Extend the assembled load to 32 bits according to the access type.
  always_comb begin
    case (ctrl_i)
      LS_B:    ldata_o = {{24{word[7]}}, word[7:0]};
      LS_H:    ldata_o = {{16{word[15]}}, word[15:0]};
      LS_BU:   ldata_o = {24'd0, word[7:0]};
      LS_HU:   ldata_o = {16'd0, word[15:0]};
      default: ldata_o = word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: takes one core access at a time, issues one or two
// word-aligned memory requests, and returns an extended load result.
// Optional feature: LSU_MISALIGN_EN enables split accesses via ACC1;
// when undefined a split access completes immediately with rsp_err.
module lsu
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_ctrl,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q;
  logic              we_q;
  logic [2:0]        ctrl_q;
  logic [1:0]        off_q;
  logic              busy_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [31:0]       rsp_rdata_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;

  logic [2:0]        al_ctrl;
  logic [1:0]        al_off;
  logic [3:0]        al_be0;
  logic [31:0]       al_wd0;
  logic [31:0]       al_ldata;
  logic              acc_ok;
  logic              final_ack;
  logic [MEM_AW-1:0] req_word_addr;

`ifdef LSU_MISALIGN_EN
  logic              split_q;
  logic [3:0]        be1_q;
  logic [31:0]       wd1_q;
  logic [31:0]       rdata0_q;
  logic [3:0]        al_be1;
  logic [31:0]       al_wd1;
  logic [31:0]       al_rdata_lo;
  logic              acc_split;
`endif

  // In IDLE the aligner looks at the incoming request, afterwards at the captured one.
  always_comb begin
    if (state_q == IDLE) begin
      al_ctrl = req_ctrl;
      al_off  = req_addr[1:0];
    end else begin
      al_ctrl = ctrl_q;
      al_off  = off_q;
    end
`ifdef LSU_MISALIGN_EN
    // For a split load the low word was captured at the ACC0 ack.
    if (state_q == ACC1) begin
      al_rdata_lo = rdata0_q;
    end else begin
      al_rdata_lo = mem_rdata;
    end
`endif
  end

  // Classify the incoming request and detect the ack that ends the access.
  always_comb begin
    req_word_addr = MEM_AW'({req_addr[31:2], 2'b00});
`ifdef LSU_MISALIGN_EN
    acc_split = ls_split(req_addr[1:0], req_ctrl);
    acc_ok    = ls_legal(req_we, req_ctrl);
    final_ack = mem_ack && (((state_q == ACC0) && !split_q) || (state_q == ACC1));
`else
    acc_ok    = ls_legal(req_we, req_ctrl) && !ls_split(req_addr[1:0], req_ctrl);
    final_ack = mem_ack && (state_q == ACC0);
`endif
  end

  lsu_align u_align (
    .ctrl_i     (al_ctrl),
    .off_i      (al_off),
    .wdata_i    (req_wdata),
`ifdef LSU_MISALIGN_EN
    .rdata_lo_i (al_rdata_lo),
    .rdata_hi_i (mem_rdata),
    .be1_o      (al_be1),
    .wdata1_o   (al_wd1),
`else
    .rdata_lo_i (mem_rdata),
`endif
    .be0_o      (al_be0),
    .wdata0_o   (al_wd0),
    .ldata_o    (al_ldata)
  );

  // Access FSM with all outputs registered; memory fields only move on accept or ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      ctrl_q      <= 3'b000;
      off_q       <= 2'b00;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'd0;
`ifdef LSU_MISALIGN_EN
      split_q     <= 1'b0;
      be1_q       <= 4'b0000;
      wd1_q       <= 32'd0;
      rdata0_q    <= 32'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          if (req_valid) begin
            we_q   <= req_we;
            ctrl_q <= req_ctrl;
            off_q  <= req_addr[1:0];
            busy_q <= 1'b1;
            if (acc_ok) begin
              state_q     <= ACC0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= req_word_addr;
              mem_be_q    <= req_we ? al_be0 : 4'b1111;
              mem_wdata_q <= req_we ? al_wd0 : 32'd0;
`ifdef LSU_MISALIGN_EN
              split_q     <= acc_split;
              be1_q       <= req_we ? al_be1 : 4'b1111;
              wd1_q       <= req_we ? al_wd1 : 32'd0;
`endif
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end
          end
        end
        ACC0: begin
`ifdef LSU_MISALIGN_EN
          if (mem_ack && split_q) begin
            state_q     <= ACC1;
            mem_addr_q  <= mem_addr_q + MEM_AW'(32'd4);
            mem_be_q    <= be1_q;
            mem_wdata_q <= wd1_q;
            rdata0_q    <= mem_rdata;
          end
`endif
        end
`ifdef LSU_MISALIGN_EN
        ACC1: begin
          // Completion handled by the final-ack branch below.
        end
`endif
        RESP: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          mem_req_q <= 1'b0;
        end
      endcase

      if (final_ack) begin
        state_q     <= RESP;
        mem_req_q   <= 1'b0;
        mem_we_q    <= 1'b0;
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= 1'b0;
        if (!we_q) begin
          rsp_rdata_q <= al_ldata;
        end
      end
    end
  end

  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: each scenario pushes the memory accesses and
// responses it expects; a negedge monitor pops and compares them.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_ctrl = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        busy;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  lsu #(.MEM_AW(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct packed {
    logic        err;
    logic        chk;
    logic [31:0] rdata;
  } rsp_exp_t;

  mem_exp_t    mem_q[$];
  rsp_exp_t    rsp_q[$];
  logic [31:0] rd_q[$];
  mem_exp_t    me;
  rsp_exp_t    re;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rsp_count = 0;
  int last_ack_cyc = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  logic force_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] bmask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Memory model: acks after ack_delay cycles of mem_req, returning queued read words.
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        mem_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
        wait_cnt = 0;
      end else begin
        mem_ack = force_ack;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      mem_ack = force_ack;
      wait_cnt = 0;
    end
  end

  // Monitor: every cycle of mem_req checks the head access; rsp_valid pops a response.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req) begin
        total++;
        if (mem_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_mem_req: got addr=%h be=%b we=%b, required no access", mem_addr, mem_be, mem_we);
        end else begin
          me = mem_q[0];
          if (mem_we !== me.we || mem_addr !== me.addr || mem_be !== me.be ||
              (me.we && ((mem_wdata & bmask(me.be)) !== (me.wdata & bmask(me.be))))) begin
            bad++;
            $display("FAIL mem_fields: got we=%b addr=%h be=%b wdata=%h, required we=%b addr=%h be=%b wdata=%h",
                     mem_we, mem_addr, mem_be, mem_wdata, me.we, me.addr, me.be, me.wdata);
          end
          if (mem_ack) begin
            void'(mem_q.pop_front());
            last_ack_cyc = cyc;
          end
        end
      end
      if (rsp_valid) begin
        rsp_count++;
        total++;
        if (rsp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rsp: got rsp_valid err=%b, required none", rsp_err);
        end else begin
          re = rsp_q.pop_front();
          if (rsp_err !== re.err || (re.chk && rsp_rdata !== re.rdata)) begin
            bad++;
            $display("FAIL rsp: got err=%b rdata=%h, required err=%b rdata=%h", rsp_err, rsp_rdata, re.err, re.rdata);
          end
          if (!re.err && cyc != last_ack_cyc + 1) begin
            bad++;
            $display("FAIL rsp_latency: got %0d cycles after ack, required 1", cyc - last_ack_cyc);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    mem_q.push_back({we, addr, be, wd});
  endtask

  task automatic exp_rsp(input logic err, input logic chk, input logic [31:0] rd);
    rsp_q.push_back({err, chk, rd});
  endtask

  task automatic issue(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                       input logic [31:0] wd, input logic legal);
    req_valid = 1'b1; req_we = we; req_ctrl = ctrl; req_addr = addr; req_wdata = wd;
    tick();
    req_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL busy_after_accept: got %b, required 1", busy);
    end
    total++;
    if (mem_req !== legal) begin
      bad++; $display("FAIL first_mem_req: got %b, required %b", mem_req, legal);
    end
  endtask

  task automatic wait_rsp();
    int start;
    bit done;
    start = rsp_count;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (rsp_count > start) done = 1'b1;
    end
    tick();
    total++;
    if (!done) begin
      bad++; $display("FAIL rsp_timeout: got no rsp_valid in 60 cycles, required one");
    end
    total++;
    if (mem_q.size() != 0 || rsp_q.size() != 0) begin
      bad++; $display("FAIL leftover: got mem=%0d rsp=%0d pending, required 0", mem_q.size(), rsp_q.size());
    end
    mem_q.delete();
    rsp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
    total++; if (rsp_valid !== 1'b0)  begin bad++; $display("FAIL rst_rsp_valid: got %b, required 0", rsp_valid); end
    total++; if (rsp_err !== 1'b0)    begin bad++; $display("FAIL rst_rsp_err: got %b, required 0", rsp_err); end
    total++; if (rsp_rdata !== 32'd0) begin bad++; $display("FAIL rst_rsp_rdata: got %h, required 0", rsp_rdata); end
    total++; if (mem_req !== 1'b0)    begin bad++; $display("FAIL rst_mem_req: got %b, required 0", mem_req); end
    total++; if (mem_we !== 1'b0)     begin bad++; $display("FAIL rst_mem_we: got %b, required 0", mem_we); end
    total++; if (mem_be !== 4'd0)     begin bad++; $display("FAIL rst_mem_be: got %b, required 0", mem_be); end
    total++; if (mem_addr !== 32'd0)  begin bad++; $display("FAIL rst_mem_addr: got %h, required 0", mem_addr); end
    total++; if (mem_wdata !== 32'd0) begin bad++; $display("FAIL rst_mem_wdata: got %h, required 0", mem_wdata); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stores();
    ack_delay = 1;
    exp_mem(1'b1, 32'h100, 4'b1111, 32'hDEADBEEF); exp_rsp(1'b0, 1'b0, 32'd0);
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b1);
    wait_rsp();
    ack_delay = 0;
    exp_mem(1'b1, 32'h100, 4'b0100, 32'h00A50000); exp_rsp(1'b0, 1'b0, 32'd0);
    issue(1'b1, 3'b000, 32'h102, 32'hFFFFFFA5, 1'b1);
    wait_rsp();
    exp_mem(1'b1, 32'h200, 4'b1100, 32'h56780000); exp_rsp(1'b0, 1'b0, 32'd0);
    issue(1'b1, 3'b001, 32'h202, 32'h00005678, 1'b1);
    wait_rsp();
  endtask

  task automatic test_loads();
    logic [2:0]  lc [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010, 3'b001};
    logic [31:0] la [7] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h200, 32'h100};
    logic [31:0] lr [7] = '{32'h80123456, 32'h80123456, 32'h8001ABCD, 32'h8001ABCD,
                            32'h00007F00, 32'hCAFEF00D, 32'h12347FFF};
    logic [31:0] lx [7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001,
                            32'h0000007F, 32'hCAFEF00D, 32'h00007FFF};
    ack_delay = 0;
    for (int i = 0; i < 7; i++) begin
      rd_q.push_back(lr[i]);
      exp_mem(1'b0, la[i] & 32'hFFFFFFFC, 4'b1111, 32'd0);
      exp_rsp(1'b0, 1'b1, lx[i]);
      issue(1'b0, lc[i], la[i], 32'd0, 1'b1);
      wait_rsp();
    end
  endtask

  task automatic test_split();
    ack_delay = 2;
`ifdef LSU_MISALIGN_EN
    exp_mem(1'b1, 32'h100, 4'b1000, 32'h34000000);
    exp_mem(1'b1, 32'h104, 4'b0001, 32'h00000012);
    exp_rsp(1'b0, 1'b0, 32'd0);
    issue(1'b1, 3'b001, 32'h103, 32'h00001234, 1'b1);
    wait_rsp();
    rd_q.push_back(32'hAABBCCDD); rd_q.push_back(32'h11223344);
    exp_mem(1'b0, 32'h100, 4'b1111, 32'd0);
    exp_mem(1'b0, 32'h104, 4'b1111, 32'd0);
    exp_rsp(1'b0, 1'b1, 32'h3344AABB);
    issue(1'b0, 3'b010, 32'h102, 32'd0, 1'b1);
    wait_rsp();
    rd_q.push_back(32'h80000000); rd_q.push_back(32'h000000FF);
    exp_mem(1'b0, 32'h100, 4'b1111, 32'd0);
    exp_mem(1'b0, 32'h104, 4'b1111, 32'd0);
    exp_rsp(1'b0, 1'b1, 32'hFFFFFF80);
    issue(1'b0, 3'b001, 32'h103, 32'd0, 1'b1);
    wait_rsp();
`else
    exp_rsp(1'b1, 1'b0, 32'd0);
    issue(1'b1, 3'b001, 32'h103, 32'h00001234, 1'b0);
    wait_rsp();
    exp_rsp(1'b1, 1'b0, 32'd0);
    issue(1'b0, 3'b010, 32'h102, 32'd0, 1'b0);
    wait_rsp();
`endif
  endtask

  task automatic test_illegal();
    logic       iw [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0] ic [5] = '{3'b101, 3'b100, 3'b011, 3'b110, 3'b111};
    ack_delay = 0;
    rd_q.push_back(32'h5A5A1234);
    exp_mem(1'b0, 32'h300, 4'b1111, 32'd0); exp_rsp(1'b0, 1'b1, 32'h5A5A1234);
    issue(1'b0, 3'b010, 32'h300, 32'd0, 1'b1);
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      exp_rsp(1'b1, 1'b1, 32'h5A5A1234);
      issue(iw[i], ic[i], 32'h300, 32'h0000FFFF, 1'b0);
      wait_rsp();
    end
  endtask

  task automatic test_stall_reset();
    int start;
    ack_delay = 5;
    exp_mem(1'b1, 32'h40, 4'b1111, 32'h0BADF00D); exp_rsp(1'b0, 1'b0, 32'd0);
    issue(1'b1, 3'b010, 32'h40, 32'h0BADF00D, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (busy !== 1'b1 || mem_req !== 1'b1) begin
        bad++; $display("FAIL stall_busy: got busy=%b mem_req=%b, required 1 1", busy, mem_req);
      end
    end
    wait_rsp();
    ack_delay = 1000;
    exp_mem(1'b1, 32'h44, 4'b1111, 32'h600DCAFE);
    issue(1'b1, 3'b010, 32'h44, 32'h600DCAFE, 1'b1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    total++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid_access: got mem_req=%b busy=%b, required 0 0", mem_req, busy);
    end
    rst = 1'b0;
    mem_q.delete();
    start = rsp_count;
    force_ack = 1'b1;
    repeat (2) tick();
    force_ack = 1'b0;
    repeat (3) tick();
    total++;
    if (rsp_count != start || busy !== 1'b0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL late_ack: got rsp=%0d busy=%b mem_req=%b, required 0 0 0", rsp_count - start, busy, mem_req);
    end
  endtask

  task automatic test_back_to_back();
    int start;
    ack_delay = 2;
    start = rsp_count;
    exp_mem(1'b1, 32'h80, 4'b1111, 32'h11111111); exp_rsp(1'b0, 1'b0, 32'd0);
    issue(1'b1, 3'b010, 32'h80, 32'h11111111, 1'b1);
    req_valid = 1'b1; req_we = 1'b0; req_ctrl = 3'b010; req_addr = 32'h90;
    repeat (4) tick();
    req_valid = 1'b0;
    total++;
    if (rsp_count != start + 1 || mem_q.size() != 0 || rsp_q.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL busy_ignore: got rsp=%0d mem_left=%0d busy=%b, required 1 0 0", rsp_count - start, mem_q.size(), busy);
    end
    mem_q.delete(); rsp_q.delete();
    ack_delay = 0;
    rd_q.push_back(32'h0000ABCD);
    exp_mem(1'b0, 32'h90, 4'b1111, 32'd0); exp_rsp(1'b0, 1'b1, 32'h0000ABCD);
    issue(1'b0, 3'b010, 32'h90, 32'd0, 1'b1);
    wait_rsp();
  endtask

  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_split();
    test_illegal();
    test_stall_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1);
  end

endmodule
